// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: bridge FSM states, access sizes, segment masks.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } bridgeState_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // kseg0/kseg1 both start with 2'b10; their physical address drops bits [31:29]
    localparam logic [1:0]  KSEG01_TAG = 2'b10;
    localparam logic [31:0] SEG_MASK   = 32'hE000_0000;

    function automatic logic isKseg01(input logic [31:0] vaddr);
        return vaddr[31:30] == KSEG01_TAG;
    endfunction

endpackage

// File: rtl/vaddr_map.sv
// Combinational virtual-to-physical mapper for unmapped kernel segments.
module vaddr_map
    import cpu_bus_pkg::*;
(
    input  logic [31:0] vaddr,
    output logic [31:0] paddr
);

    always_comb begin
        paddr = vaddr;
        if (isKseg01(vaddr)) paddr = vaddr & ~SEG_MASK;
    end

endmodule

// File: rtl/d_sramlike_bridge.sv
// Data-side bridge from the M-stage memory port to the sram-like data bus.
// Optional kseg0/kseg1 address mapping enabled by defining DBRIDGE_ADDR_MAP_EN.
module d_sramlike_bridge
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_wen,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [ADDR_W-1:0] cpu_wdata,
    input  logic              cpu_longest_stall,
    output logic [ADDR_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [ADDR_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [ADDR_W-1:0] data_rdata
);

    bridgeState_t state, nextState;

    logic [3:0]        wenQ;
    logic [1:0]        sizeQ;
    logic [ADDR_W-1:0] addrQ, wdataQ, rdataQ;
    logic [ADDR_W-1:0] vAddr;
    logic [3:0]        reqWen;
    logic              issueLive, dataDone;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (cpu_en)            nextState = data_addr_ok ? DATA : ADDR;
            ADDR: if (data_addr_ok)      nextState = DATA;
            DATA: if (data_data_ok)      nextState = cpu_longest_stall ? DONE : IDLE;
            DONE: if (!cpu_longest_stall) nextState = IDLE;
            default:                     nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wenQ   <= '0;
            sizeQ  <= '0;
            addrQ  <= '0;
            wdataQ <= '0;
            rdataQ <= '0;
        end else begin
            if (state == IDLE && cpu_en) begin
                wenQ   <= cpu_wen;
                sizeQ  <= cpu_size;
                addrQ  <= cpu_addr;
                wdataQ <= cpu_wdata;
            end
            if (dataDone) rdataQ <= data_rdata;
        end
    end

    // Live fields only during the IDLE issue cycle; afterwards the bus sees the
    // captured copy so the pipeline may move its M-stage inputs freely.
    always_comb begin
        issueLive  = (state == IDLE) && cpu_en;
        dataDone   = (state == DATA) && data_data_ok;
        data_req   = issueLive || (state == ADDR);
        reqWen     = issueLive ? cpu_wen   : wenQ;
        data_size  = issueLive ? cpu_size  : sizeQ;
        vAddr      = issueLive ? cpu_addr  : addrQ;
        data_wdata = issueLive ? cpu_wdata : wdataQ;
        data_wr    = |reqWen;
        cpu_stall  = cpu_en && !dataDone && (state != DONE);
        cpu_rdata  = dataDone ? data_rdata : rdataQ;
    end

`ifdef DBRIDGE_ADDR_MAP_EN
    vaddr_map uMap (
        .vaddr (vAddr),
        .paddr (data_addr)
    );
`else
    assign data_addr = vAddr;
`endif

endmodule

// File: tb/tb_d_sramlike_bridge.sv
// Scoreboard bench for d_sramlike_bridge: stimulus pushes expectations, a negedge monitor checks them.
module tb_d_sramlike_bridge;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } busReq_t;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } probe_t;

    localparam int P_REQ = 0, P_STALL = 1, P_RDATA = 2, P_ADDR = 3, P_WR = 4,
                   P_SIZE = 5, P_CNT = 6, P_REQQ = 7, P_RDQ = 8;

`ifdef DBRIDGE_ADDR_MAP_EN
    localparam logic [31:0] EXP_BOOT = 32'h1FC0_0010;
    localparam logic [31:0] EXP_K0   = 32'h0000_0040;
`else
    localparam logic [31:0] EXP_BOOT = 32'hBFC0_0010;
    localparam logic [31:0] EXP_K0   = 32'h8000_0040;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cpuEn = 1'b0;
    logic [3:0]  cpuWen = '0;
    logic [1:0]  cpuSize = '0;
    logic [31:0] cpuAddr = '0;
    logic [31:0] cpuWdata = '0;
    logic        otherStall = 1'b0;
    logic        longestStall;
    logic [31:0] cpuRdata;
    logic        cpuStall;
    logic        dataReq, dataWr;
    logic [1:0]  dataSize;
    logic [31:0] dataAddr, dataWdata;
    logic        addrOk = 1'b0;
    logic        dataOk = 1'b0;
    logic [31:0] busRdata = '0;

    busReq_t     reqQ[$];
    logic [31:0] rdQ[$];
    probe_t      probeQ[$];
    int          checks = 0;
    int          errors = 0;
    int          acceptCnt = 0;

    assign longestStall = cpuStall | otherStall;

    always #5 clk = ~clk;

    d_sramlike_bridge #(.ADDR_W(32)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .cpu_en            (cpuEn),
        .cpu_wen           (cpuWen),
        .cpu_size          (cpuSize),
        .cpu_addr          (cpuAddr),
        .cpu_wdata         (cpuWdata),
        .cpu_longest_stall (longestStall),
        .cpu_rdata         (cpuRdata),
        .cpu_stall         (cpuStall),
        .data_req          (dataReq),
        .data_wr           (dataWr),
        .data_size         (dataSize),
        .data_addr         (dataAddr),
        .data_wdata        (dataWdata),
        .data_addr_ok      (addrOk),
        .data_data_ok      (dataOk),
        .data_rdata        (busRdata)
    );

    // Monitor: probes first, then bus acceptances, then load/store completions.
    always @(negedge clk) begin
        while (probeQ.size() > 0) begin
            probe_t      p;
            logic [31:0] act;
            p = probeQ.pop_front();
            case (p.sel)
                P_REQ:   act = {31'd0, dataReq};
                P_STALL: act = {31'd0, cpuStall};
                P_RDATA: act = cpuRdata;
                P_ADDR:  act = dataAddr;
                P_WR:    act = {31'd0, dataWr};
                P_SIZE:  act = {30'd0, dataSize};
                P_CNT:   act = acceptCnt;
                P_REQQ:  act = reqQ.size();
                default: act = rdQ.size();
            endcase
            checks++;
            if (act !== p.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h at %0t", p.name, act, p.exp, $time);
            end
        end
        if (resetn && dataReq && addrOk) begin
            busReq_t got;
            got = '{wr: dataWr, size: dataSize, addr: dataAddr, wdata: dataWdata};
            acceptCnt++;
            checks++;
            if (reqQ.size() == 0) begin
                errors++;
                $display("FAIL busReq: unexpected request %h at %0t", got, $time);
            end else begin
                busReq_t e;
                e = reqQ.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL busReq: got %h expected %h at %0t", got, e, $time);
                end
            end
        end
        if (resetn && cpuEn && dataOk && !cpuStall) begin
            checks++;
            if (rdQ.size() == 0) begin
                errors++;
                $display("FAIL complete: unexpected completion rdata %h at %0t", cpuRdata, $time);
            end else begin
                logic [31:0] e;
                e = rdQ.pop_front();
                if (cpuRdata !== e) begin
                    errors++;
                    $display("FAIL complete: got %h expected %h at %0t", cpuRdata, e, $time);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string name, input int sel, input logic [31:0] exp);
        probe_t p;
        p.name = name;
        p.sel  = sel;
        p.exp  = exp;
        probeQ.push_back(p);
    endtask

    task automatic issue(input logic [3:0] wen, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic ok, input logic [31:0] expAddr);
        busReq_t r;
        cpuEn    = 1'b1;
        cpuWen   = wen;
        cpuSize  = size;
        cpuAddr  = addr;
        cpuWdata = wdata;
        addrOk   = ok;
        r = '{wr: |wen, size: size, addr: expAddr, wdata: wdata};
        reqQ.push_back(r);
    endtask

    task automatic idleInputs();
        cpuEn  = 1'b0;
        cpuWen = '0;
        addrOk = 1'b0;
        dataOk = 1'b0;
    endtask

    initial begin
        // reset state
        probe("rstReq", P_REQ, 0);
        probe("rstStall", P_STALL, 0);
        probe("rstRdata", P_RDATA, 0);
        cyc(); cyc();
        resetn = 1'b1;

        // word load to boot ROM, addr_ok same cycle, data_ok next
        cyc();
        issue(4'b0000, 2'd2, 32'hBFC0_0010, 32'h0, 1'b1, EXP_BOOT);
        rdQ.push_back(32'h1234_5678);
        probe("t1Req", P_REQ, 1);
        probe("t1Addr", P_ADDR, EXP_BOOT);
        probe("t1StallC0", P_STALL, 1);
        cyc();
        addrOk = 1'b0; dataOk = 1'b1; busRdata = 32'h1234_5678;
        probe("t1StallC1", P_STALL, 0);
        probe("t1ReqC1", P_REQ, 0);
        cyc();
        idleInputs(); busRdata = 32'hDEAD_BEEF;
        probe("t1Hold", P_RDATA, 32'h1234_5678);
        probe("t1StallIdle", P_STALL, 0);

        // byte store, addr_ok after 3 cycles of waiting
        cyc();
        issue(4'b0100, 2'd0, 32'h0000_2002, 32'h00AB_0000, 1'b0, 32'h0000_2002);
        rdQ.push_back(32'h0);
        probe("t2Wr", P_WR, 1);
        probe("t2Size", P_SIZE, 0);
        for (int i = 1; i <= 3; i++) begin
            probe("t2Req", P_REQ, 1);
            probe("t2Stall", P_STALL, 1);
            cyc();
            if (i == 3) addrOk = 1'b1;
        end
        probe("t2ReqC3", P_REQ, 1);
        probe("t2WrC3", P_WR, 1);
        cyc();
        addrOk = 1'b0;
        probe("t2ReqData", P_REQ, 0);
        probe("t2StallData", P_STALL, 1);
        cyc();
        dataOk = 1'b1; busRdata = 32'h0;
        probe("t2Release", P_STALL, 0);
        cyc();
        idleInputs();

        // load completes under another stall; held in DONE for 5 cycles
        cyc();
        otherStall = 1'b1;
        issue(4'b0000, 2'd2, 32'h0000_3000, 32'h0, 1'b1, 32'h0000_3000);
        rdQ.push_back(32'hCAFE_F00D);
        cyc();
        addrOk = 1'b0; dataOk = 1'b1; busRdata = 32'hCAFE_F00D;
        probe("t3Done", P_STALL, 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            dataOk = 1'b0; addrOk = 1'b1; busRdata = 32'h5555_0000 + i;
            probe("t3DoneReq", P_REQ, 0);
            probe("t3DoneStall", P_STALL, 0);
            probe("t3DoneRdata", P_RDATA, 32'hCAFE_F00D);
            if (i == 4) otherStall = 1'b0;
        end
        cyc();
        idleInputs();
        probe("t3OneReq", P_CNT, 3);
        probe("t3IdleReq", P_REQ, 0);

        // address and wen change after capture while addr_ok is delayed
        cyc();
        issue(4'b0000, 2'd2, 32'h8000_0040, 32'h0, 1'b0, EXP_K0);
        rdQ.push_back(32'h0BAD_F00D);
        cyc();
        cpuAddr = 32'h0000_5555; cpuWen = 4'hF;
        probe("t4Addr", P_ADDR, EXP_K0);
        probe("t4Wr", P_WR, 0);
        cyc();
        addrOk = 1'b1;
        cyc();
        addrOk = 1'b0; dataOk = 1'b1; busRdata = 32'h0BAD_F00D;
        cyc();
        idleInputs();

        // reset pulse while in DATA, then a stray data_ok
        cyc();
        issue(4'b0000, 2'd2, 32'h0000_6000, 32'h0, 1'b1, 32'h0000_6000);
        cyc();
        addrOk = 1'b0; cpuEn = 1'b0; resetn = 1'b0;
        probe("t5RstReq", P_REQ, 0);
        probe("t5RstStall", P_STALL, 0);
        probe("t5RstRdata", P_RDATA, 0);
        cyc();
        resetn = 1'b1; dataOk = 1'b1; busRdata = 32'hFFFF_FFFF;
        probe("t5StrayStall", P_STALL, 0);
        probe("t5StrayRdata", P_RDATA, 0);
        probe("t5StrayReq", P_REQ, 0);
        cyc();
        dataOk = 1'b0;
        probe("t5RdataQ", P_RDATA, 0);

        // back-to-back loads, second issued right after completion
        cyc();
        issue(4'b0000, 2'd2, 32'h0000_7000, 32'h0, 1'b1, 32'h0000_7000);
        rdQ.push_back(32'h1111_1111);
        cyc();
        addrOk = 1'b0; dataOk = 1'b1; busRdata = 32'h1111_1111;
        cyc();
        dataOk = 1'b0;
        issue(4'b0000, 2'd2, 32'h0000_7004, 32'h0, 1'b1, 32'h0000_7004);
        rdQ.push_back(32'h2222_2222);
        probe("t6Req2", P_REQ, 1);
        probe("t6Addr2", P_ADDR, 32'h0000_7004);
        cyc();
        addrOk = 1'b0; dataOk = 1'b1; busRdata = 32'h2222_2222;
        cyc();
        idleInputs();
        probe("finalCnt", P_CNT, 7);
        probe("reqQEmpty", P_REQQ, 0);
        probe("rdQEmpty", P_RDQ, 0);
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
